// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - lock-qualified multi-channel clock-enable and square-wave generator
module clk_en_gen #(
    parameter int NCH      = 4,
    parameter int DIV_W    = 8,
    parameter int LOCK_CNT = 16
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             stdby,
    input  logic             extlock,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic [NCH-1:0]   clk_en,
    output logic [NCH-1:0]   clk_sq,
    output logic             locked,
    output logic [NCH-1:0]   cfg_pend
);
    localparam int LCW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, ALIGN, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LCW-1:0] lock_cnt;
    logic           run_go;

    always_comb begin
        state_nxt = state;
        if (stdby) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_LOCK;
                WAIT_LOCK: if (extlock && lock_cnt == LOCK_LAST) state_nxt = ALIGN;
                ALIGN:     state_nxt = RUN;
                RUN:       if (!extlock) state_nxt = WAIT_LOCK;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_LOCK && state_nxt == WAIT_LOCK && extlock)
                lock_cnt <= lock_cnt + 1'b1;
            else
                lock_cnt <= '0;
        end
    end

    assign locked = (state == RUN);

    // Channels only advance when this cycle and the next are both RUN, so a
    // departure from RUN never leaves a stray pulse on the outputs.
    assign run_go = (state == RUN) && (state_nxt == RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] div_sh;
        logic [DIV_W-1:0] ph_sh;
        logic [DIV_W-1:0] div_act;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] eff;
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] sh_last;
        logic [DIV_W-1:0] ph_load;
        logic             wr_hit;
        logic             wrap;
        logic             en_q;
        logic             sq_q;
        logic             pend_q;

        assign wr_hit  = cfg_wr && (cfg_ch == 3'(i));
        assign eff     = (div_act == '0) ? DIV_W'(1) : div_act;
        assign last    = eff - 1'b1;
        assign wrap    = (cnt == last);
        assign sh_last = ((div_sh == '0) ? DIV_W'(1) : div_sh) - 1'b1;
        assign ph_load = (ph_sh < sh_last) ? ph_sh : sh_last;

        always_ff @(posedge refclk) begin
            if (!reset) begin
                div_sh  <= DIV_W'(1);
                ph_sh   <= '0;
                div_act <= DIV_W'(1);
                cnt     <= '0;
                en_q    <= 1'b0;
                sq_q    <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                en_q <= run_go && wrap;
                sq_q <= run_go && (cnt < (eff >> 1));
                if (state == ALIGN) begin
                    div_act <= div_sh;
                    cnt     <= ph_load;
                    pend_q  <= 1'b0;
                end else if (run_go) begin
                    if (wrap) begin
                        cnt <= '0;
                        if (pend_q) begin
                            div_act <= div_sh;
                            pend_q  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A write landing on a wrap keeps the flag set: the old shadow
                // was just applied, the new one waits for the next wrap.
                if (wr_hit) begin
                    div_sh <= cfg_div;
                    ph_sh  <= cfg_phase;
                    pend_q <= 1'b1;
                end
            end
        end

        assign clk_en[i]   = en_q;
        assign clk_sq[i]   = sq_q;
        assign cfg_pend[i] = pend_q;
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - self-checking bench for clk_en_gen
module tb_clk_en_gen;
    localparam int NCH      = 4;
    localparam int DIV_W    = 8;
    localparam int LOCK_CNT = 16;

    logic             refclk = 1'b0;
    logic             reset;
    logic             stdby;
    logic             extlock;
    logic             cfg_wr;
    logic [2:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic [NCH-1:0]   clk_en;
    logic [NCH-1:0]   clk_sq;
    logic             locked;
    logic [NCH-1:0]   cfg_pend;

    clk_en_gen #(.NCH(NCH), .DIV_W(DIV_W), .LOCK_CNT(LOCK_CNT)) dut (
        .refclk    (refclk),
        .reset     (reset),
        .stdby     (stdby),
        .extlock   (extlock),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .clk_en    (clk_en),
        .clk_sq    (clk_sq),
        .locked    (locked),
        .cfg_pend  (cfg_pend)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string          name;
        logic [NCH-1:0] en;
        logic [NCH-1:0] sq;
        logic [NCH-1:0] pend;
        logic           lk;
    } exp_t;

    typedef struct {
        string name;
        int    ch;
        int    div;
        int    phase;
        int    first;
        int    per;
        int    hi;
    } vec_t;

    exp_t           sb[$];
    vec_t           vecs[9];
    int             n_cmp = 0;
    int             n_err = 0;
    int             m_first[NCH];
    int             m_per[NCH];
    int             m_hi[NCH];
    logic [NCH-1:0] m_pend;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NCH; i++) begin
            m_first[i] = 1;
            m_per[i]   = 1;
            m_hi[i]    = 0;
        end
        m_pend = '0;
    endtask

    task automatic check();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (clk_en !== e.en || clk_sq !== e.sq || locked !== e.lk || cfg_pend !== e.pend) begin
            n_err++;
            $display("FAIL %s: got en=%b sq=%b locked=%b pend=%b, expected en=%b sq=%b locked=%b pend=%b",
                     e.name, clk_en, clk_sq, locked, cfg_pend, e.en, e.sq, e.lk, e.pend);
        end
    endtask

    task automatic step(input string name, input logic lk, input logic [NCH-1:0] en,
                        input logic [NCH-1:0] sq);
        exp_t e;
        e.name = name;
        e.lk   = lk;
        e.en   = en;
        e.sq   = sq;
        e.pend = m_pend;
        sb.push_back(e);
        tick();
        check();
    endtask

    // Outputs seen in RUN cycle k come from the counter in cycle k-1.
    task automatic run_step(input string name, input int k);
        logic [NCH-1:0] en;
        logic [NCH-1:0] sq;
        int             ph;
        for (int i = 0; i < NCH; i++) begin
            ph    = (k - m_first[i] + m_per[i] - 1) % m_per[i];
            en[i] = (k > 0) && (ph == m_per[i] - 1);
            sq[i] = (k > 0) && (ph < m_hi[i]);
        end
        step(name, 1'b1, en, sq);
    endtask

    task automatic expect_lock(input string name, input int n_low);
        for (int i = 0; i < n_low; i++) step(name, 1'b0, '0, '0);
        m_pend = '0;
        run_step(name, 0);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        cfg_wr = 1'b0;
        m_pend = '0;
        step("reset", 1'b0, '0, '0);
        reset   = 1'b1;
        stdby   = 1'b1;
        extlock = 1'b0;
        set_defaults();
    endtask

    task automatic cfg_idle(input int ch, input int div, input int phase);
        cfg_wr    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = DIV_W'(div);
        cfg_phase = DIV_W'(phase);
        if (ch < NCH) m_pend[ch] = 1'b1;
        step("cfg_write", 1'b0, '0, '0);
        cfg_wr = 1'b0;
    endtask

    task automatic lock_up(input string name);
        stdby   = 1'b0;
        extlock = 1'b1;
        expect_lock(name, LOCK_CNT + 1);
    endtask

    initial begin
        reset = 1'b0; stdby = 1'b1; extlock = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        set_defaults();
        step("reset_state", 1'b0, '0, '0);
        step("reset_state", 1'b0, '0, '0);
        reset = 1'b1;

        vecs[0] = '{"div4_ph0", 0, 4, 0, 4, 4, 2};
        vecs[1] = '{"div4_ph2", 1, 4, 2, 2, 4, 2};
        vecs[2] = '{"div4_ph9_clamp", 3, 4, 9, 1, 4, 2};
        vecs[3] = '{"div5_ph1", 2, 5, 1, 4, 5, 2};
        vecs[4] = '{"div0", 0, 0, 0, 1, 1, 0};
        vecs[5] = '{"div1_ph5", 1, 1, 5, 1, 1, 0};
        vecs[6] = '{"div3_ph0", 2, 3, 0, 3, 3, 1};
        vecs[7] = '{"bad_ch4", 4, 9, 0, 1, 1, 0};
        vecs[8] = '{"bad_ch7", 7, 2, 1, 1, 1, 0};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            cfg_idle(vecs[v].ch, vecs[v].div, vecs[v].phase);
            if (vecs[v].ch < NCH) begin
                m_first[vecs[v].ch] = vecs[v].first;
                m_per[vecs[v].ch]   = vecs[v].per;
                m_hi[vecs[v].ch]    = vecs[v].hi;
            end
            lock_up(vecs[v].name);
            for (int k = 1; k <= 12; k++) run_step(vecs[v].name, k);
        end

        // extlock glitch part-way through the lock count
        do_reset();
        stdby   = 1'b0;
        extlock = 1'b1;
        for (int i = 0; i < 11; i++) step("glitch_pre", 1'b0, '0, '0);
        extlock = 1'b0;
        step("glitch_low", 1'b0, '0, '0);
        extlock = 1'b1;
        expect_lock("glitch_relock", LOCK_CNT);
        for (int k = 1; k <= 3; k++) run_step("glitch_run", k);

        // two channels with phase offset, then standby and lock loss
        do_reset();
        cfg_idle(0, 4, 0);
        cfg_idle(1, 4, 2);
        m_first[0] = 4; m_per[0] = 4; m_hi[0] = 2;
        m_first[1] = 2; m_per[1] = 4; m_hi[1] = 2;
        lock_up("two_ch_lock");
        for (int k = 1; k <= 12; k++) run_step("two_ch", k);
        stdby = 1'b1;
        step("stdby_idle", 1'b0, '0, '0);
        step("stdby_hold", 1'b0, '0, '0);
        lock_up("stdby_relock");
        for (int k = 1; k <= 8; k++) run_step("stdby_run", k);
        extlock = 1'b0;
        step("lock_drop", 1'b0, '0, '0);
        extlock = 1'b1;
        expect_lock("lock_drop_relock", LOCK_CNT);
        for (int k = 1; k <= 4; k++) run_step("lock_drop_run", k);

        // reconfigure in RUN, second write on a wrap cycle
        do_reset();
        cfg_idle(2, 3, 0);
        m_first[2] = 3; m_per[2] = 3; m_hi[2] = 1;
        lock_up("reconfig_lock");
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) begin
                cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd6; cfg_phase = 8'd0;
                m_pend[2] = 1'b1;
            end
            if (k == 6) begin
                cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd2; cfg_phase = 8'd0;
                m_first[2] = 6; m_per[2] = 6; m_hi[2] = 3;
            end
            if (k == 12) begin
                m_first[2] = 12; m_per[2] = 2; m_hi[2] = 1;
                m_pend[2] = 1'b0;
            end
            run_step("reconfig", k);
            cfg_wr = 1'b0;
        end

        // reset while running, then shadows must be back to divide-by-1
        do_reset();
        lock_up("post_reset_lock");
        for (int k = 1; k <= 3; k++) run_step("post_reset_run", k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
